// File: rtl/rom_download_ctrl_pkg.sv
// Shared types for the ROM download path: word/address typedefs, FSM states
// and the little-endian byte placement helper.
package rom_download_ctrl_pkg;

    localparam int SDRAM_AW = 23;

    typedef logic [31:0]         word_t;
    typedef logic [SDRAM_AW-1:0] sdram_addr_t;

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    // Byte lane n lands in bits [8n+7:8n].
    function automatic word_t place_byte(input word_t w, input logic [1:0] lane,
                                         input logic [7:0] b);
        word_t r;
        r = w;
        r[{lane, 3'b000} +: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/rom_download_ctrl_word_fifo.sv
// Small synchronous FIFO holding packed {address, data} SDRAM write entries.
// The head entry is visible combinationally and stays put until popped.
module word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 55,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/rom_download_ctrl.sv
// Packs the HPS ioctl byte stream into 32-bit SDRAM writes and hands the SDRAM
// port back to the game core once the download has been fully written.
module rom_download_ctrl
    import rom_download_ctrl_pkg::*;
#(
    parameter int IOCTL_ADDR_WIDTH = 20,
    parameter int SDRAM_ADDR_WIDTH = 23,
    parameter int BASE_ADDR        = 0,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [IOCTL_ADDR_WIDTH-1:0] ioctl_addr,
    input  logic [7:0]                  ioctl_data,
    input  logic                        ioctl_wr,
    input  logic                        ioctl_download,
    output logic                        ioctl_wait,
    input  logic [SDRAM_ADDR_WIDTH-1:0] game_addr,
    input  logic [31:0]                 game_data,
    input  logic                        game_we,
    input  logic                        game_req,
    output logic                        game_ack,
    output logic                        game_valid,
    output logic [31:0]                 game_q,
    output logic [SDRAM_ADDR_WIDTH-1:0] sdram_addr,
    output logic [31:0]                 sdram_data,
    output logic                        sdram_we,
    output logic                        sdram_req,
    input  logic                        sdram_ack,
    input  logic                        sdram_valid,
    input  logic [31:0]                 sdram_q,
    output logic                        busy,
    output logic                        done,
    output logic                        overflow
);

    localparam int AW = SDRAM_ADDR_WIDTH;
    localparam int EW = AW + 32;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t          state;
    logic            asm_valid, asm_valid_nxt;
    logic [AW-1:0]   asm_waddr, asm_waddr_nxt;
    word_t           asm_data, asm_data_nxt;
    logic            dl_prev;
    logic            dl_seen;

    logic [AW-1:0]   byte_waddr;
    logic [1:0]      lane;
    word_t           merged_word;
    word_t           fresh_word;
    logic            push;
    logic [EW-1:0]   push_entry;
    logic            pop;
    logic [EW-1:0]   head;
    logic            fifo_full, fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic            dl_req;

    assign lane        = ioctl_addr[1:0];
    assign byte_waddr  = AW'(BASE_ADDR) + AW'(ioctl_addr[IOCTL_ADDR_WIDTH-1:2]);
    assign merged_word = place_byte(asm_valid ? asm_data : '0, lane, ioctl_data);
    assign fresh_word  = place_byte('0, lane, ioctl_data);

    always_comb begin
        push          = 1'b0;
        push_entry    = {asm_waddr, asm_data};
        asm_valid_nxt = asm_valid;
        asm_waddr_nxt = asm_waddr;
        asm_data_nxt  = asm_data;
        if (ioctl_wr) begin
            if (asm_valid && asm_waddr != byte_waddr) begin
                // Address jump: flush the held partial, the new byte starts over.
                push          = 1'b1;
                asm_valid_nxt = 1'b1;
                asm_waddr_nxt = byte_waddr;
                asm_data_nxt  = fresh_word;
            end else if (lane == 2'd3) begin
                push          = 1'b1;
                push_entry    = {byte_waddr, merged_word};
                asm_valid_nxt = 1'b0;
                asm_data_nxt  = '0;
            end else begin
                asm_valid_nxt = 1'b1;
                asm_waddr_nxt = byte_waddr;
                asm_data_nxt  = merged_word;
            end
        end else if (dl_prev && !ioctl_download && asm_valid) begin
            push          = 1'b1;
            asm_valid_nxt = 1'b0;
            asm_data_nxt  = '0;
        end
    end

    assign pop = (state == WRITE) && sdram_ack;

    word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            asm_valid  <= 1'b0;
            asm_waddr  <= '0;
            asm_data   <= '0;
            dl_prev    <= 1'b0;
            dl_seen    <= 1'b0;
            overflow   <= 1'b0;
            ioctl_wait <= 1'b0;
        end else begin
            asm_valid  <= asm_valid_nxt;
            asm_waddr  <= asm_waddr_nxt;
            asm_data   <= asm_data_nxt;
            dl_prev    <= ioctl_download;
            ioctl_wait <= (fifo_count >= CW'(FIFO_DEPTH - 1));
            if (push && fifo_full && !pop)
                overflow <= 1'b1;
            if (ioctl_download)
                dl_seen <= 1'b1;
            case (state)
                IDLE: begin
                    if (!fifo_empty)
                        state <= WRITE;
                    else if (dl_seen && !ioctl_download && !asm_valid) begin
                        state   <= DONE;
                        dl_seen <= 1'b0;
                    end
                end
                WRITE: begin
                    if (sdram_ack && fifo_count == CW'(1))
                        state <= IDLE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign done   = (state == DONE);
    assign dl_req = (state == WRITE);
    assign busy   = ioctl_download || !fifo_empty || (state != IDLE);

    // The game core sees the SDRAM only while the download path is idle.
    assign sdram_addr = busy ? head[EW-1:32] : game_addr;
    assign sdram_data = busy ? head[31:0]    : game_data;
    assign sdram_we   = busy ? dl_req        : game_we;
    assign sdram_req  = busy ? dl_req        : game_req;
    assign game_ack   = busy ? 1'b0          : sdram_ack;
    assign game_valid = busy ? 1'b0          : sdram_valid;
    assign game_q     = busy ? '0            : sdram_q;

endmodule
